// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for param_fifo and its storage sub-module:
//   clog2     - ceiling log2, used for pointer and occupancy widths
//   MODE_STD  - standard registered read mode
//   MODE_FWFT - first-word-fall-through read mode
//   ptr_inc   - pointer increment that wraps explicitly at depth-1, so
//               non-power-of-two depths work without modulo arithmetic
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int MODE_STD  = 0;
   localparam int MODE_FWFT = 1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int unsigned ptr_inc(input int unsigned ptr,
                                           input int unsigned depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// D x W storage array for param_fifo. Contents are never reset.
//   clk      in   clock; writes happen on the rising edge
//   we_i     in   write enable
//   waddr_i  in   write address (0..D-1)
//   wdata_i  in   write data
//   raddr_i  in   read address (0..D-1)
//   rdata_o  out  asynchronous read data at raddr_i
// -----------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int W  = 8,
   parameter int D  = 16,
   parameter int AW = clog2(D)
)(
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [0:D-1];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Asynchronous read lets FWFT mode present the head word combinationally
   // and lets standard mode register it in the same cycle the pop is accepted.
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
// Parametrised single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, occupancy count, sticky error flags
// and selectable standard or first-word-fall-through read mode.
//   clk           in   clock
//   rst           in   asynchronous active-low reset
//   wr_en         in   write request
//   data_in       in   write data
//   rd_en         in   read/pop request
//   clr_err       in   clears OVERFLOW and UNDERFLOW (a same-cycle set wins)
//   data_out      out  read data
//   rd_valid      out  standard: data_out updated this cycle; FWFT: !EMPTY
//   count         out  occupancy
//   FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  out  registered status flags
//   OVERFLOW      out  sticky, a write was rejected
//   UNDERFLOW     out  sticky, a read was rejected
// -----------------------------------------------------------------------------
module param_fifo
   import fifo_pkg::*;
#(
   parameter int W     = 8,
   parameter int D     = 16,
   parameter int AF_TH = D - 1,
   parameter int AE_TH = 1,
   parameter int FWFT  = MODE_STD
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [W-1:0]          data_in,
   input  logic                  rd_en,
   input  logic                  clr_err,
   output logic [W-1:0]          data_out,
   output logic                  rd_valid,
   output logic [clog2(D+1)-1:0] count,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int PW = clog2(D);
   localparam int CW = clog2(D + 1);

   // Elaboration-time parameter checks
   if (D < 2) begin : g_bad_depth
      $error("param_fifo: D must be at least 2");
   end
   if (AF_TH < 1 || AF_TH > D) begin : g_bad_af_th
      $error("param_fifo: AF_TH must be in 1..D");
   end
   if (AE_TH < 0 || AE_TH > D - 1) begin : g_bad_ae_th
      $error("param_fifo: AE_TH must be in 0..D-1");
   end
   if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
      $error("param_fifo: FWFT must be 0 or 1");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          af_q, af_d;
   logic          ae_q, ae_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          rd_acc;
   logic          wr_acc;
   logic [W-1:0]  mem_rdata;

   // A read frees a slot in the same cycle, so a full FIFO still accepts a
   // write when it is also being popped.
   assign rd_acc = rd_en && !empty_q;
   assign wr_acc = wr_en && (!full_q || rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (wr_acc) begin
         wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), D));
      end
      if (rd_acc) begin
         rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), D));
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Flags derive from the next count so they register in step with it.
      full_d  = (count_d == CW'(D));
      empty_d = (count_d == '0);
      af_d    = (count_d >= CW'(AF_TH));
      ae_d    = (count_d <= CW'(AE_TH));

      // Set has priority over clear.
      ovf_d = ovf_q;
      if (wr_en && !wr_acc) begin
         ovf_d = 1'b1;
      end else if (clr_err) begin
         ovf_d = 1'b0;
      end

      udf_d = udf_q;
      if (rd_en && !rd_acc) begin
         udf_d = 1'b1;
      end else if (clr_err) begin
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_mem #(
      .W  (W),
      .D  (D),
      .AW (PW)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

   if (FWFT == MODE_FWFT) begin : g_fwft
      // Head word is visible as soon as it is stored; zero while empty.
      assign data_out = empty_q ? '0 : mem_rdata;
      assign rd_valid = !empty_q;
   end else begin : g_std
      logic [W-1:0] dout_q;
      logic         rv_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            dout_q <= '0;
            rv_q   <= 1'b0;
         end else begin
            rv_q <= rd_acc;
            if (rd_acc) begin
               dout_q <= mem_rdata;
            end
         end
      end

      assign data_out = dout_q;
      assign rd_valid = rv_q;
   end

   assign count        = count_q;
   assign FULL         = full_q;
   assign EMPTY        = empty_q;
   assign ALMOST_FULL  = af_q;
   assign ALMOST_EMPTY = ae_q;
   assign OVERFLOW     = ovf_q;
   assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_fifo
// Bench for param_fifo with W=8, D=5, AF_TH=4, AE_TH=1. One instance in
// standard mode, one in FWFT mode. Queue-based reference models are checked
// against both instances every falling edge; directed steps add literal
// expectations.
// -----------------------------------------------------------------------------
module tb_param_fifo;

   localparam int W  = 8;
   localparam int D  = 5;
   localparam int CW = $clog2(D + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // standard-mode instance
   logic          wr_en = 1'b0;
   logic [W-1:0]  data_in = '0;
   logic          rd_en = 1'b0;
   logic          clr_err = 1'b0;
   logic [W-1:0]  s_dout;
   logic          s_rv;
   logic [CW-1:0] s_count;
   logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;

   // FWFT-mode instance
   logic          f_wr_en = 1'b0;
   logic [W-1:0]  f_data_in = '0;
   logic          f_rd_en = 1'b0;
   logic          f_clr_err = 1'b0;
   logic [W-1:0]  f_dout;
   logic          f_rv;
   logic [CW-1:0] f_count;
   logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

   param_fifo #(.W(W), .D(D), .AF_TH(4), .AE_TH(1), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .clr_err(clr_err), .data_out(s_dout), .rd_valid(s_rv), .count(s_count),
      .FULL(s_full), .EMPTY(s_empty), .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae),
      .OVERFLOW(s_ovf), .UNDERFLOW(s_udf)
   );

   param_fifo #(.W(W), .D(D), .AF_TH(4), .AE_TH(1), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
      .clr_err(f_clr_err), .data_out(f_dout), .rd_valid(f_rv), .count(f_count),
      .FULL(f_full), .EMPTY(f_empty), .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae),
      .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model, standard instance ----------------
   logic [W-1:0] mq[$];
   logic [W-1:0] m_dout = '0;
   bit m_rv = 0, m_ovf = 0, m_udf = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_dout = '0;
         m_rv = 0; m_ovf = 0; m_udf = 0;
      end else begin
         bit ra, wa;
         ra = rd_en && (mq.size() > 0);
         wa = wr_en && ((mq.size() < D) || ra);
         if (wr_en && !wa) m_ovf = 1; else if (clr_err) m_ovf = 0;
         if (rd_en && !ra) m_udf = 1; else if (clr_err) m_udf = 0;
         m_rv = ra;
         if (ra) m_dout = mq.pop_front();
         if (wa) mq.push_back(data_in);
      end
   end

   // ---------------- reference model, FWFT instance ----------------
   logic [W-1:0] fq[$];
   bit f_movf = 0, f_mudf = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         fq.delete();
         f_movf = 0; f_mudf = 0;
      end else begin
         bit ra, wa;
         ra = f_rd_en && (fq.size() > 0);
         wa = f_wr_en && ((fq.size() < D) || ra);
         if (f_wr_en && !wa) f_movf = 1; else if (f_clr_err) f_movf = 0;
         if (f_rd_en && !ra) f_mudf = 1; else if (f_clr_err) f_mudf = 0;
         if (ra) void'(fq.pop_front());
         if (wa) fq.push_back(f_data_in);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("count",        int'(s_count), mq.size());
      chk("FULL",         int'(s_full),  int'(mq.size() == D));
      chk("EMPTY",        int'(s_empty), int'(mq.size() == 0));
      chk("ALMOST_FULL",  int'(s_af),    int'(mq.size() >= 4));
      chk("ALMOST_EMPTY", int'(s_ae),    int'(mq.size() <= 1));
      chk("data_out",     int'(s_dout),  int'(m_dout));
      chk("rd_valid",     int'(s_rv),    int'(m_rv));
      chk("OVERFLOW",     int'(s_ovf),   int'(m_ovf));
      chk("UNDERFLOW",    int'(s_udf),   int'(m_udf));

      chk("f_count",      int'(f_count), fq.size());
      chk("f_EMPTY",      int'(f_empty), int'(fq.size() == 0));
      chk("f_FULL",       int'(f_full),  int'(fq.size() == D));
      chk("f_data_out",   int'(f_dout),  (fq.size() > 0) ? int'(fq[0]) : 0);
      chk("f_rd_valid",   int'(f_rv),    int'(fq.size() > 0));
      chk("f_OVERFLOW",   int'(f_ovf),   int'(f_movf));
      chk("f_UNDERFLOW",  int'(f_udf),   int'(f_mudf));
   end

   // Apply inputs at a falling edge, return at the next falling edge.
   task automatic cyc(input bit we, input int d, input bit re, input bit c);
      wr_en   = we;
      data_in = W'(d);
      rd_en   = re;
      clr_err = c;
      @(negedge clk);
      $display("cyc wr=%0b din=%02h rd=%0b clr=%0b -> count=%0d dout=%02h rv=%0b ovf=%0b udf=%0b",
               we, d, re, c, s_count, s_dout, s_rv, s_ovf, s_udf);
   endtask

   initial begin
      #2 rst = 1'b0;
      @(negedge clk);
      // reset state
      chk("rst count", int'(s_count), 0);
      chk("rst EMPTY", int'(s_empty), 1);
      chk("rst FULL", int'(s_full), 0);
      chk("rst AE", int'(s_ae), 1);
      chk("rst AF", int'(s_af), 0);
      chk("rst data_out", int'(s_dout), 0);
      chk("rst rd_valid", int'(s_rv), 0);
      chk("rst OVERFLOW", int'(s_ovf), 0);
      rst = 1'b1;

      // 1. fill
      for (int i = 0; i < 5; i++) begin
         cyc(1, 'h11 * (i + 1), 0, 0);
         chk("fill count", int'(s_count), i + 1);
         chk("fill AE", int'(s_ae), (i == 0) ? 1 : 0);
         chk("fill AF", int'(s_af), (i >= 3) ? 1 : 0);
         chk("fill FULL", int'(s_full), (i == 4) ? 1 : 0);
      end
      cyc(1, 'h66, 0, 0);
      chk("ovf flag", int'(s_ovf), 1);
      chk("ovf count", int'(s_count), 5);

      // 2. drain
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1, 0);
         chk("drain data", int'(s_dout), 'h11 * (i + 1));
         chk("drain rd_valid", int'(s_rv), 1);
      end
      chk("drain EMPTY", int'(s_empty), 1);
      cyc(0, 0, 1, 0);
      chk("udf flag", int'(s_udf), 1);
      chk("udf rd_valid", int'(s_rv), 0);
      chk("udf data hold", int'(s_dout), 'h55);

      // 6. error clear
      cyc(0, 0, 0, 1);
      chk("clr OVERFLOW", int'(s_ovf), 0);
      chk("clr UNDERFLOW", int'(s_udf), 0);
      cyc(0, 0, 1, 1);
      chk("set wins UNDERFLOW", int'(s_udf), 1);
      cyc(0, 0, 0, 1);
      chk("reclr UNDERFLOW", int'(s_udf), 0);

      // 3. full, simultaneous read/write, wrap
      for (int i = 0; i < 5; i++) cyc(1, 'hB0 + i, 0, 0);
      chk("wrap full", int'(s_full), 1);
      for (int i = 0; i < 7; i++) begin
         cyc(1, 'hA0 + i, 1, 0);
         chk("rw data", int'(s_dout), (i < 5) ? ('hB0 + i) : ('hA0 + i - 5));
         chk("rw count", int'(s_count), 5);
         chk("rw OVERFLOW", int'(s_ovf), 0);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1, 0);
         chk("wrap drain", int'(s_dout), 'hA2 + i);
      end

      // 4. mid-operation reset
      for (int i = 0; i < 3; i++) cyc(1, 'hC1 + i, 0, 0);
      cyc(0, 0, 0, 0);
      chk("pre-rst count", int'(s_count), 3);
      #2 rst = 1'b0;
      #1;
      chk("async EMPTY", int'(s_empty), 1);
      chk("async count", int'(s_count), 0);
      chk("async data_out", int'(s_dout), 0);
      chk("async FULL", int'(s_full), 0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1, 'h77, 0, 0);
      cyc(0, 0, 1, 0);
      chk("post-rst data", int'(s_dout), 'h77);
      chk("post-rst rd_valid", int'(s_rv), 1);
      cyc(0, 0, 0, 0);

      // 5. FWFT
      chk("fwft idle data", int'(f_dout), 0);
      f_wr_en = 1'b1; f_data_in = 8'hA5;
      @(negedge clk);
      f_wr_en = 1'b0; f_data_in = '0;
      $display("fwft write A5 -> empty=%0b dout=%02h", f_empty, f_dout);
      chk("fwft EMPTY", int'(f_empty), 0);
      chk("fwft data", int'(f_dout), 'hA5);
      chk("fwft rd_valid", int'(f_rv), 1);
      f_rd_en = 1'b1;
      @(negedge clk);
      f_rd_en = 1'b0;
      $display("fwft pop -> empty=%0b dout=%02h", f_empty, f_dout);
      chk("fwft pop EMPTY", int'(f_empty), 1);
      chk("fwft pop data", int'(f_dout), 0);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
